// File: rtl/analyzer_cfg_spi_master.sv
// Mode-0 SPI master that sends queued {cmd, data} register writes as 40-bit frames.
// CS_N falls two cycles after a push into an empty queue; req_ready drops while the queue is full.

module analyzer_cfg_req_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;

  // Extra pointer bit tells a full queue apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_rdy  = !full;
  assign out_vld = !empty;
  assign out_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge SCLK) begin
    if (in_vld && !full) begin
      mem[wr_ptr[AW-1:0]] <= in_dat;
    end
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (in_vld && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (out_rdy && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

module analyzer_cfg_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_sel,
  input  logic [31:0] req_data,
  output logic        SCK,
  output logic        MOSI,
  output logic        CS_N,
  input  logic        MISO,
  output logic        busy,
  output logic        done,
  output logic        match_flag
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL, GAP} state_t;

  state_t        state;
  logic [38:0]   shreg;
  logic [5:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic          shadow;
  logic          fifo_vld;
  logic          fifo_pop;
  logic [39:0]   fifo_dat;

  assign fifo_pop = (state == IDLE) && fifo_vld;

  analyzer_cfg_req_fifo #(.WIDTH(40), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .SCLK    (SCLK),
    .RST     (RST),
    .in_vld  (req_valid),
    .in_rdy  (req_ready),
    .in_dat  ({(req_sel ? 8'h02 : 8'h01), req_data}),
    .out_vld (fifo_vld),
    .out_rdy (fifo_pop),
    .out_dat (fifo_dat)
  );

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      shadow     <= 1'b0;
      SCK        <= 1'b0;
      MOSI       <= 1'b0;
      CS_N       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      match_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_vld) begin
            shreg   <= fifo_dat[38:0];
            MOSI    <= fifo_dat[39];
            CS_N    <= 1'b0;
            SCK     <= 1'b0;
            bit_cnt <= 6'd39;
            div_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // First high cycle of the last bit is where the analyzer's flag is valid.
          if (SCK && (div_cnt == '0) && (bit_cnt == 6'd0)) begin
            shadow <= MISO;
          end
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!SCK) begin
              SCK <= 1'b1;
            end else begin
              SCK <= 1'b0;
              if (bit_cnt == 6'd0) begin
                state <= TRAIL;
              end else begin
                bit_cnt <= bit_cnt - 6'd1;
                MOSI    <= shreg[38];
                shreg   <= {shreg[37:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            CS_N       <= 1'b1;
            done       <= 1'b1;
            match_flag <= shadow;
            MOSI       <= 1'b0;
            gap_cnt    <= '0;
            state      <= GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
